// File: rtl/npc_bus_pkg.sv
// Shared encodings for the core's memory-bus arbiter: states, owners, arbitration modes.
package npc_bus_pkg;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    localparam logic PRIO_FIXED = 1'b0;
    localparam logic PRIO_RR    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } owner_e;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way grant between IFU and LSU, fixed-priority or round-robin.
module mem_arb_pick
    import npc_bus_pkg::*;
(
    input  logic   ifu_valid_i,
    input  logic   lsu_valid_i,
    input  owner_e last_grant_i,
    input  logic   mode_i,
    output owner_e grant_o
);
    always_comb begin
        grant_o = OWN_NONE;
        if (ifu_valid_i && lsu_valid_i) begin
            if (mode_i == PRIO_RR) begin
                grant_o = (last_grant_i == OWN_LSU) ? OWN_IFU : OWN_LSU;
            end else begin
                grant_o = OWN_LSU;
            end
        end else if (lsu_valid_i) begin
            grant_o = OWN_LSU;
        end else if (ifu_valid_i) begin
            grant_o = OWN_IFU;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the single data-memory port between IFU and LSU, one transaction at a time,
// with a grant-to-response watchdog that converts a hung access into an error pulse.
module mem_arbiter
    import npc_bus_pkg::*;
#(
    parameter int PRIORITY = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [DATA_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    output logic [DATA_W-1:0] ifu_rsp_data,
    output logic              ifu_rsp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [DATA_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rsp_data,
    output logic              lsu_rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
);
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    owner_e            grant;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wen_q, mem_wen_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;
    logic              ifu_rsp_valid_q, ifu_rsp_valid_d;
    logic              lsu_rsp_valid_q, lsu_rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              wdog_fire;

    mem_arb_pick u_pick (
        .ifu_valid_i  (ifu_req_valid),
        .lsu_valid_i  (lsu_req_valid),
        .last_grant_i (last_q),
        .mode_i       (1'(PRIORITY)),
        .grant_o      (grant)
    );

    // cnt_q holds cycles elapsed since the grant, so firing here puts the error
    // pulse exactly TIMEOUT cycles after the grant cycle.
    assign wdog_fire = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= 32'(TIMEOUT));

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_d          = last_q;
        cnt_d           = cnt_q;
        mem_addr_d      = mem_addr_q;
        mem_wen_d       = mem_wen_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wmask_d     = mem_wmask_q;
        ifu_rsp_valid_d = 1'b0;
        lsu_rsp_valid_d = 1'b0;
        rsp_data_d      = '0;
        rsp_err_d       = 1'b0;
        ifu_req_ready   = 1'b0;
        lsu_req_ready   = 1'b0;
        mem_req_valid   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rst && grant != OWN_NONE) begin
                    owner_d = grant;
                    last_d  = grant;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_REQ;
                    if (grant == OWN_LSU) begin
                        lsu_req_ready = 1'b1;
                        mem_addr_d    = lsu_addr;
                        mem_wen_d     = lsu_wen;
                        mem_wdata_d   = lsu_wdata;
                        mem_wmask_d   = lsu_wmask;
                    end else begin
                        ifu_req_ready = 1'b1;
                        mem_addr_d    = ifu_addr;
                        mem_wen_d     = 1'b0;
                        mem_wdata_d   = '0;
                        mem_wmask_d   = '0;
                    end
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                cnt_d         = cnt_q + CNT_W'(1);
                if (mem_req_ready) begin
                    state_d = ST_RSP;
                end else if (wdog_fire) begin
                    rsp_err_d = 1'b1;
                    if (owner_q == OWN_LSU) lsu_rsp_valid_d = 1'b1;
                    else                    ifu_rsp_valid_d = 1'b1;
                    owner_d = OWN_NONE;
                    state_d = ST_IDLE;
                end
            end
            ST_RSP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rsp_valid || wdog_fire) begin
                    // A real response on the timeout edge still wins.
                    rsp_err_d  = !mem_rsp_valid;
                    rsp_data_d = (mem_rsp_valid && !mem_wen_q) ? mem_rsp_data : '0;
                    if (owner_q == OWN_LSU) lsu_rsp_valid_d = 1'b1;
                    else                    ifu_rsp_valid_d = 1'b1;
                    owner_d = OWN_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                owner_d = OWN_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_NONE;
            last_q          <= OWN_IFU;
            cnt_q           <= '0;
            mem_addr_q      <= '0;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            rsp_data_q      <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_q          <= last_d;
            cnt_q           <= cnt_d;
            mem_addr_q      <= mem_addr_d;
            mem_wen_q       <= mem_wen_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wmask_q     <= mem_wmask_d;
            ifu_rsp_valid_q <= ifu_rsp_valid_d;
            lsu_rsp_valid_q <= lsu_rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_err_q       <= rsp_err_d;
        end
    end

    assign mem_addr      = mem_addr_q;
    assign mem_wen       = mem_wen_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign ifu_rsp_valid = ifu_rsp_valid_q;
    assign ifu_rsp_data  = ifu_rsp_valid_q ? rsp_data_q : '0;
    assign ifu_rsp_err   = ifu_rsp_valid_q & rsp_err_q;
    assign lsu_rsp_valid = lsu_rsp_valid_q;
    assign lsu_rsp_data  = lsu_rsp_valid_q ? rsp_data_q : '0;
    assign lsu_rsp_err   = lsu_rsp_valid_q & rsp_err_q;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data-memory port between the instruction-fetch unit (IFU) and the load/store unit (MEM/LSU) for the multi-cycle core.
- Accepts one request at a time through a valid/ready handshake, forwards it to memory, and waits for the memory response.
- Routes the response back to the owning requester as a one-cycle pulse.
- Includes a watchdog that turns a hung access into an error response.

Parameters:
- PRIORITY, 0: arbitration mode. 0 = fixed priority, LSU wins. 1 = round-robin between the two requesters.
- TIMEOUT, 255: maximum cycles from grant to response before an error is returned. 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  32  IFU fetch address
- ifu_rsp_valid  out  1  one-cycle IFU response pulse
- ifu_rsp_data  out  32  fetched word
- ifu_rsp_err  out  1  IFU access timed out
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  32  LSU address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  32  store data
- lsu_wmask  in  4  byte strobes
- lsu_rsp_valid  out  1  one-cycle LSU response pulse
- lsu_rsp_data  out  32  load data (0 for stores)
- lsu_rsp_err  out  1  LSU access timed out
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  32  latched write data
- mem_wmask  out  4  latched strobes
- mem_rsp_valid  in  1  memory response or write acknowledge
- mem_rsp_data  in  32  memory read data

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset state: state = IDLE, owner = none, last_grant = IFU, watchdog count = 0.
- Reset outputs: all outputs 0. ifu_req_ready and lsu_req_ready are forced to 0 while rst is high.
- Reset mid-operation: the in-flight transaction is dropped and no response is issued.
- States: IDLE, REQ, RSP.
- IDLE, grant selection:
  - Exactly one valid requester: that requester is granted.
  - Both valid, PRIORITY=0: LSU is granted.
  - Both valid, PRIORITY=1: the requester not in last_grant is granted.
- IDLE, grant cycle:
  - The grantee's req_ready is driven combinationally high in the same cycle.
  - Request fields are latched into the mem_* registers. IFU is latched as wen=0, wmask=0, wdata=0.
  - owner and last_grant are updated, then go to REQ.
  - req_ready is never high outside IDLE and never high for both requesters.
- REQ: mem_req_valid = 1 with stable latched fields. When mem_req_ready = 1 at a clock edge, go to RSP and drop mem_req_valid.
- RSP: wait for mem_rsp_valid.
  - On mem_rsp_valid, the next cycle pulses the owner's rsp_valid for exactly one cycle.
  - rsp_data = mem_rsp_data for loads and fetches, 0 for stores. err = 0.
  - The state returns to IDLE, so a new grant can occur in the same cycle as the rsp_valid pulse.
- Watchdog:
  - Counts cycles in REQ and RSP, cleared on every grant.
  - If TIMEOUT≠0 and the count reaches TIMEOUT with no response, the owner gets rsp_valid=1, err=1, data=0, and the state goes to IDLE.
  - A response arriving on the same edge as the timeout wins, and err = 0.
- mem_rsp_valid in IDLE or REQ is ignored.
- No backpressure on responses: requesters must consume the pulse.
- Minimum latency, with mem_req_ready tied high and memory responding one cycle after accept:
  - grant at cycle 0
  - mem handshake at cycle 1
  - mem_rsp_valid at cycle 2
  - rsp_valid at cycle 3
  - Throughput is one transaction per 3 cycles.

Decomposition:
- Shared package npc_bus_pkg:
  - arbiter state encoding (IDLE/REQ/RSP)
  - owner encoding (NONE/IFU/LSU)
  - PRIORITY mode constants (PRIO_FIXED=0, PRIO_RR=1)
  - MASK_W=4 and DATA_W=32
- Sub-module mem_arb_pick: purely combinational 2-way grant from the two valids, last_grant and mode. Instantiated once; keeps the grant logic unit-testable.

Test Plan:
- IFU-only read, PRIORITY=0, ifu_addr=0x80000000, memory returns 0x00000413 one cycle after accept -> ifu_req_ready at cycle 0, ifu_rsp_valid at cycle 3 with data 0x00000413, err=0; lsu_rsp_valid stays 0.
- Both valid at cycle 0, PRIORITY=0, LSU store to 0x80001000 with wdata=0xDEADBEEF, wmask=0xF -> LSU granted first and mem_wen=1; lsu_rsp_data=0 on ack. IFU granted on the cycle of lsu_rsp_valid.
- PRIORITY=1, both held valid for 4 transactions -> grant order LSU, IFU, LSU, IFU (last_grant resets to IFU).
- mem_req_ready held low for 5 cycles -> mem_req_valid and mem_addr/wdata/wmask stable throughout; advance to RSP on the first ready edge.
- TIMEOUT=8, memory never responds -> owner's rsp_valid=1, err=1, data=0 exactly 8 cycles after grant; a new request is accepted afterwards.
- rst asserted asynchronously while in RSP -> all outputs 0 immediately; a later mem_rsp_valid is ignored; the next request is handled normally after rst deasserts.
